// File: rtl/vram_arbiter_if.sv
// Bundle of the video, CPU, DMA and VRAM-side signals around the VRAM arbiter.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface vram_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  // video scan-out
  logic              vid_slot;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  // CPU bus
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [DATA_W-1:0] cpu_dout;
  logic              cpu_ack;
  // DMA engine
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_din;
  logic [DATA_W-1:0] dma_dout;
  logic              dma_ack;
  // VRAM port
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  vid_slot, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  dma_req, dma_we, dma_addr, dma_din,
    input  ram_dout,
    output vid_data, vid_valid,
    output cpu_dout, cpu_ack,
    output dma_dout, dma_ack,
    output ram_addr, ram_din, ram_we
  );

  modport master (
    output vid_slot, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output dma_req, dma_we, dma_addr, dma_din,
    output ram_dout,
    input  vid_data, vid_valid,
    input  cpu_dout, cpu_ack,
    input  dma_dout, dma_ack,
    input  ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video on fixed slots, CPU/DMA share the rest.
// Optional macro VRAM_CPU_PRIO_EN: CPU-priority arbitration with DMA starvation guard.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  owner_e            w_grant;
  owner_e            r_s1_owner;
  logic              r_s1_we;

  logic              r_cpu_busy;
  logic              r_dma_busy;
  logic              w_cpu_elig;
  logic              w_dma_elig;
  logic              w_contest;
  logic              w_dma_wins;

  logic [DATA_W-1:0] r_vid_data;
  logic              r_vid_valid;
  logic [DATA_W-1:0] r_cpu_dout;
  logic              r_cpu_ack;
  logic [DATA_W-1:0] r_dma_dout;
  logic              r_dma_ack;

  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;
  logic              w_ram_we;

  // A requester stays ineligible from its grant until the end of its ack cycle.
  assign w_cpu_elig = bus.cpu_req & ~r_cpu_busy;
  assign w_dma_elig = bus.dma_req & ~r_dma_busy;
  assign w_contest  = ~reset & ~bus.vid_slot & w_cpu_elig & w_dma_elig;

`ifdef VRAM_CPU_PRIO_EN
  localparam int CNT_W = $clog2(DMA_MAX_WAIT) + 1;

  logic [CNT_W-1:0] r_wait_cnt;

  assign w_dma_wins = (r_wait_cnt >= CNT_W'(DMA_MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset || !bus.dma_req || (w_grant == OWN_DMA)) begin
      r_wait_cnt <= '0;
    end else if (w_dma_elig && (w_grant == OWN_CPU)) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end
`else
  logic r_rr_cpu_next;
  logic w_unused_cfg;

  assign w_dma_wins   = ~r_rr_cpu_next;
  assign w_unused_cfg = (DMA_MAX_WAIT > 0);

  // Pointer only moves on a real contest, and always towards the loser.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_cpu_next <= 1'b1;
    end else if (w_contest) begin
      r_rr_cpu_next <= (w_grant == OWN_DMA);
    end
  end
`endif

  always_comb begin
    w_grant = OWN_NONE;
    if (reset) begin
      w_grant = OWN_NONE;
    end else if (bus.vid_slot) begin
      w_grant = OWN_VID;
    end else if (w_contest) begin
      w_grant = w_dma_wins ? OWN_DMA : OWN_CPU;
    end else if (w_cpu_elig) begin
      w_grant = OWN_CPU;
    end else if (w_dma_elig) begin
      w_grant = OWN_DMA;
    end
  end

  always_comb begin
    w_ram_addr = '0;
    w_ram_din  = '0;
    w_ram_we   = 1'b0;
    unique case (w_grant)
      OWN_VID: begin
        w_ram_addr = bus.vid_addr;
      end
      OWN_CPU: begin
        w_ram_addr = bus.cpu_addr;
        w_ram_din  = bus.cpu_din;
        w_ram_we   = bus.cpu_we;
      end
      OWN_DMA: begin
        w_ram_addr = bus.dma_addr;
        w_ram_din  = bus.dma_din;
        w_ram_we   = bus.dma_we;
      end
      default: begin
      end
    endcase
  end

  assign bus.ram_addr = w_ram_addr;
  assign bus.ram_din  = w_ram_din;
  assign bus.ram_we   = w_ram_we;

  // Stage 1 remembers who owns the read data that VRAM returns next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_owner  <= OWN_NONE;
      r_s1_we     <= 1'b0;
      r_cpu_busy  <= 1'b0;
      r_dma_busy  <= 1'b0;
      r_vid_data  <= '0;
      r_vid_valid <= 1'b0;
      r_cpu_dout  <= '0;
      r_cpu_ack   <= 1'b0;
      r_dma_dout  <= '0;
      r_dma_ack   <= 1'b0;
    end else begin
      r_s1_owner <= w_grant;
      r_s1_we    <= (w_grant == OWN_CPU) ? bus.cpu_we :
                    (w_grant == OWN_DMA) ? bus.dma_we : 1'b0;

      r_vid_valid <= (r_s1_owner == OWN_VID);
      r_cpu_ack   <= (r_s1_owner == OWN_CPU);
      r_dma_ack   <= (r_s1_owner == OWN_DMA);

      if (r_s1_owner == OWN_VID) begin
        r_vid_data <= bus.ram_dout;
      end
      if ((r_s1_owner == OWN_CPU) && !r_s1_we) begin
        r_cpu_dout <= bus.ram_dout;
      end
      if ((r_s1_owner == OWN_DMA) && !r_s1_we) begin
        r_dma_dout <= bus.ram_dout;
      end

      if (w_grant == OWN_CPU) begin
        r_cpu_busy <= 1'b1;
      end else if (r_cpu_ack) begin
        r_cpu_busy <= 1'b0;
      end

      if (w_grant == OWN_DMA) begin
        r_dma_busy <= 1'b1;
      end else if (r_dma_ack) begin
        r_dma_busy <= 1'b0;
      end
    end
  end

  assign bus.vid_data  = r_vid_data;
  assign bus.vid_valid = r_vid_valid;
  assign bus.cpu_dout  = r_cpu_dout;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.dma_dout  = r_dma_dout;
  assign bus.dma_ack   = r_dma_ack;

endmodule
